// File: rtl/ro_pkg.sv
// Shared types and constants for the ring-oscillator frequency comparison chain.
// The default count width is shared with the downstream up/down counter.
package ro_pkg;

  localparam int RO_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    EVAL  = 2'd2
  } ro_state_e;

endpackage

// File: rtl/ro_edge_sync.sv
// Brings one asynchronous ring-oscillator output into the clk domain and
// flags each rising edge as a single-cycle pulse.
module ro_edge_sync
  import ro_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   prev_q;
  logic                   prev_d;

  // Shift chain and previous-value flop inputs.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
    prev_d = sync_q[SYNC_STAGES-1];
  end

  // Synchronizer and edge-detect registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign rise_pulse = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/ro_freq_compare.sv
// Counts ro_a/ro_b rising edges over a fixed gate window and emits one up or
// down pulse per window according to which oscillator ran faster.
module ro_freq_compare
  import ro_pkg::*;
#(
  parameter int WINDOW_CYCLES = 1024,
  parameter int CNT_W         = RO_CNT_W,
  parameter int DEADBAND      = 0,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ro_a,
  input  logic             ro_b,
  output logic             up_out,
  output logic             down_out,
  output logic             window_done,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
  localparam int CMP_W = CNT_W + 1;
  localparam logic [WIN_W-1:0] WIN_LAST     = WIN_W'(WINDOW_CYCLES - 1);
  localparam logic [CMP_W-1:0] DEADBAND_EXT = CMP_W'(DEADBAND);
  localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};

  ro_state_e        state_q, state_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] edge_a_q, edge_a_d;
  logic [CNT_W-1:0] edge_b_q, edge_b_d;
  logic             up_q, up_d;
  logic             down_q, down_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
  logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

  logic             rise_a_s;
  logic             rise_b_s;
  logic [CMP_W-1:0] a_ext_s;
  logic [CMP_W-1:0] b_ext_s;
  logic             a_gt_s;
  logic             b_gt_s;

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .clk        (clk),
    .reset      (reset),
    .async_in   (ro_a),
    .rise_pulse (rise_a_s)
  );

  ro_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .clk        (clk),
    .reset      (reset),
    .async_in   (ro_b),
    .rise_pulse (rise_b_s)
  );

  // One extra bit keeps count + DEADBAND from overflowing.
  always_comb begin
    a_ext_s = {1'b0, edge_a_q};
    b_ext_s = {1'b0, edge_b_q};
    a_gt_s  = (a_ext_s > (b_ext_s + DEADBAND_EXT));
    b_gt_s  = (b_ext_s > (a_ext_s + DEADBAND_EXT));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a dropped enable aborts a window in progress.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (enable) state_d = COUNT;
        else        state_d = IDLE;
      end
      COUNT: begin
        if (!enable)               state_d = IDLE;
        else if (win_q == WIN_LAST) state_d = EVAL;
        else                       state_d = COUNT;
      end
      EVAL: begin
        if (enable) state_d = COUNT;
        else        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Window and saturating edge counters; only live while in COUNT.
  always_comb begin
    win_d    = win_q;
    edge_a_d = edge_a_q;
    edge_b_d = edge_b_q;
    case (state_q)
      COUNT: begin
        if (enable) begin
          win_d = win_q + WIN_W'(1);
          if (rise_a_s && (edge_a_q != CNT_MAX)) edge_a_d = edge_a_q + CNT_W'(1);
          else                                   edge_a_d = edge_a_q;
          if (rise_b_s && (edge_b_q != CNT_MAX)) edge_b_d = edge_b_q + CNT_W'(1);
          else                                   edge_b_d = edge_b_q;
        end else begin
          win_d    = '0;
          edge_a_d = '0;
          edge_b_d = '0;
        end
      end
      IDLE, EVAL: begin
        win_d    = '0;
        edge_a_d = '0;
        edge_b_d = '0;
      end
      default: begin
        win_d    = '0;
        edge_a_d = '0;
        edge_b_d = '0;
      end
    endcase
  end

  // Output logic: the EVAL-cycle decision is registered for the next cycle.
  always_comb begin
    up_d    = 1'b0;
    down_d  = 1'b0;
    done_d  = 1'b0;
    cnt_a_d = cnt_a_q;
    cnt_b_d = cnt_b_q;
    if (state_q == EVAL) begin
      up_d    = a_gt_s;
      down_d  = b_gt_s;
      done_d  = 1'b1;
      cnt_a_d = edge_a_q;
      cnt_b_d = edge_b_q;
    end else begin
      up_d    = 1'b0;
      down_d  = 1'b0;
      done_d  = 1'b0;
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
    end
  end

  // Counter and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_q    <= '0;
      edge_a_q <= '0;
      edge_b_q <= '0;
      up_q     <= 1'b0;
      down_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
    end else begin
      win_q    <= win_d;
      edge_a_q <= edge_a_d;
      edge_b_q <= edge_b_d;
      up_q     <= up_d;
      down_q   <= down_d;
      done_q   <= done_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
    end
  end

  assign up_out      = up_q;
  assign down_out    = down_q;
  assign window_done = done_q;
  assign cnt_a       = cnt_a_q;
  assign cnt_b       = cnt_b_q;

endmodule

// File: tb/tb_ro_freq_compare.sv
// Scoreboard bench for ro_freq_compare: three instances share stimulus
// (baseline, DEADBAND=1, CNT_W=4) with a 64-cycle gate window.
module tb_ro_freq_compare;

  localparam int WIN = 64;
  localparam int LAT = WIN + 2;

  logic clk = 1'b0;
  logic reset, enable, ro_a, ro_b;

  logic        up, down, done;
  logic [15:0] cnt_a, cnt_b;
  logic        db_up, db_down, db_done;
  logic [15:0] db_cnt_a, db_cnt_b;
  logic        sat_up, sat_down, sat_done;
  logic [3:0]  sat_cnt_a, sat_cnt_b;

  int checks = 0;
  int errors = 0;
  int cyc_cnt = 0;

  typedef struct packed {
    logic        up;
    logic        down;
    logic [15:0] a;
    logic [15:0] b;
  } res_t;

  typedef struct {
    res_t       m;
    logic       m_up_nx, m_down_nx, m_done_nx;
    logic       db_up, db_down, db_done;
    logic       sat_up, sat_done;
    logic [3:0] sat_a;
    logic [3:0] sat_b;
  } obs_t;

  res_t sb_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  ro_freq_compare #(.WINDOW_CYCLES(WIN), .CNT_W(16), .DEADBAND(0), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ro_a(ro_a), .ro_b(ro_b),
    .up_out(up), .down_out(down), .window_done(done), .cnt_a(cnt_a), .cnt_b(cnt_b)
  );

  ro_freq_compare #(.WINDOW_CYCLES(WIN), .CNT_W(16), .DEADBAND(1), .SYNC_STAGES(2)) dut_db (
    .clk(clk), .reset(reset), .enable(enable), .ro_a(ro_a), .ro_b(ro_b),
    .up_out(db_up), .down_out(db_down), .window_done(db_done), .cnt_a(db_cnt_a), .cnt_b(db_cnt_b)
  );

  ro_freq_compare #(.WINDOW_CYCLES(WIN), .CNT_W(4), .DEADBAND(0), .SYNC_STAGES(2)) dut_sat (
    .clk(clk), .reset(reset), .enable(enable), .ro_a(ro_a), .ro_b(ro_b),
    .up_out(sat_up), .down_out(sat_down), .window_done(sat_done), .cnt_a(sat_cnt_a), .cnt_b(sat_cnt_b)
  );

  // Optionally (re)starts a window, drives na/nb 2-high/2-low pulses after
  // `pre` cycles, then waits (bounded) for window_done and captures outputs.
  task automatic run_window(input bit do_enable, input int pre, input int na, input int nb,
                            output obs_t o, output bit to, output int lat);
    int en_cyc;
    int n;
    o.m = 'x;
    ro_a = 1'b0;
    ro_b = 1'b0;
    if (do_enable) begin
      enable = 1'b0;
      repeat (2) @(negedge clk);
      enable = 1'b1;
    end
    en_cyc = cyc_cnt;
    repeat (pre) @(negedge clk);
    n = (na > nb) ? na : nb;
    for (int i = 0; i < n; i++) begin
      ro_a = (i < na);
      ro_b = (i < nb);
      repeat (2) @(negedge clk);
      ro_a = 1'b0;
      ro_b = 1'b0;
      repeat (2) @(negedge clk);
    end
    to = 1'b1;
    for (int k = 0; k < 200 && to; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        o.m      = {up, down, cnt_a, cnt_b};
        o.db_up  = db_up;
        o.db_down = db_down;
        o.db_done = db_done;
        o.sat_up = sat_up;
        o.sat_done = sat_done;
        o.sat_a  = sat_cnt_a;
        o.sat_b  = sat_cnt_b;
        to = 1'b0;
      end
    end
    lat = cyc_cnt - en_cyc;
    @(negedge clk);
    o.m_up_nx   = up;
    o.m_down_nx = down;
    o.m_done_nx = done;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({up, down, done, cnt_a, cnt_b, db_up, db_down, db_done, db_cnt_a, db_cnt_b,
         sat_up, sat_down, sat_done, sat_cnt_a, sat_cnt_b} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got up=%b down=%b done=%b a=%h b=%h want all zero",
               up, down, done, cnt_a, cnt_b);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    obs_t o; bit to; int lat; res_t e;
    sb_q.push_back({1'b1, 1'b0, 16'd5, 16'd3});
    run_window(1'b1, 4, 5, 3, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to) begin errors++; $display("FAIL basic_timeout no window_done within bound"); end
    checks++;
    if (o.m !== e) begin errors++; $display("FAIL basic_result got %h want %h", o.m, e); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL basic_latency got %0d want %0d", lat, LAT); end
    checks++;
    if ({o.m_up_nx, o.m_down_nx, o.m_done_nx} !== 3'b000) begin
      errors++;
      $display("FAIL basic_single_cycle got %b want 000", {o.m_up_nx, o.m_down_nx, o.m_done_nx});
    end
  endtask

  task automatic test_swapped_equal();
    obs_t o; bit to; int lat; res_t e;
    sb_q.push_back({1'b0, 1'b1, 16'd3, 16'd5});
    run_window(1'b1, 4, 3, 5, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to || o.m !== e) begin errors++; $display("FAIL swapped_result got %h want %h timeout=%b", o.m, e, to); end
    sb_q.push_back({1'b0, 1'b0, 16'd4, 16'd4});
    run_window(1'b1, 4, 4, 4, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to || o.m !== e) begin errors++; $display("FAIL equal_result got %h want %h timeout=%b", o.m, e, to); end
  endtask

  task automatic test_deadband();
    obs_t o; bit to; int lat; res_t e;
    sb_q.push_back({1'b1, 1'b0, 16'd5, 16'd4});
    run_window(1'b1, 4, 5, 4, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to || o.m !== e) begin errors++; $display("FAIL db0_result got %h want %h timeout=%b", o.m, e, to); end
    checks++;
    if ({o.db_up, o.db_down, o.db_done} !== 3'b001) begin
      errors++; $display("FAIL db1_within got %b want 001", {o.db_up, o.db_down, o.db_done});
    end
    sb_q.push_back({1'b1, 1'b0, 16'd6, 16'd4});
    run_window(1'b1, 4, 6, 4, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to || o.m !== e) begin errors++; $display("FAIL db0_result2 got %h want %h timeout=%b", o.m, e, to); end
    checks++;
    if ({o.db_up, o.db_down, o.db_done} !== 3'b101) begin
      errors++; $display("FAIL db1_exceeded got %b want 101", {o.db_up, o.db_down, o.db_done});
    end
  endtask

  task automatic test_saturation();
    obs_t o; bit to; int lat; res_t e;
    sb_q.push_back({1'b1, 1'b0, 16'd16, 16'd0});
    run_window(1'b1, 0, 16, 0, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to || o.m !== e) begin errors++; $display("FAIL sat_wide_result got %h want %h timeout=%b", o.m, e, to); end
    checks++;
    if ({o.sat_a, o.sat_b, o.sat_up, o.sat_done} !== {4'd15, 4'd0, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sat_narrow got a=%0d b=%0d up=%b done=%b want a=15 b=0 up=1 done=1",
               o.sat_a, o.sat_b, o.sat_up, o.sat_done);
    end
  endtask

  task automatic test_abort();
    obs_t o; bit to; int lat; res_t e; int hits;
    sb_q.push_back({1'b1, 1'b0, 16'd5, 16'd3});
    run_window(1'b1, 4, 5, 3, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to || o.m !== e) begin errors++; $display("FAIL abort_setup got %h want %h timeout=%b", o.m, e, to); end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 30; k++) begin
      ro_a = (k >= 4) && (k < 20) && ((k % 4) < 2);
      ro_b = (k >= 4) && (k < 12) && ((k % 4) < 2);
      @(negedge clk);
    end
    enable = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    hits = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (done || up || down) hits++;
    end
    checks++;
    if (hits != 0) begin errors++; $display("FAIL abort_pulses got %0d pulse cycles want 0", hits); end
    checks++;
    if ({cnt_a, cnt_b} !== {16'd5, 16'd3}) begin
      errors++; $display("FAIL abort_hold got a=%0d b=%0d want a=5 b=3", cnt_a, cnt_b);
    end
    sb_q.push_back({1'b0, 1'b1, 16'd2, 16'd6});
    run_window(1'b1, 4, 2, 6, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to || o.m !== e) begin errors++; $display("FAIL abort_rerun got %h want %h timeout=%b", o.m, e, to); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL abort_rerun_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_reset_mid_window();
    obs_t o; bit to; int lat; res_t e;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 20; k++) begin
      ro_a = (k >= 4) && (k < 16) && ((k % 4) < 2);
      @(negedge clk);
    end
    ro_a = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({up, down, done, cnt_a, cnt_b} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs got up=%b down=%b done=%b a=%0d b=%0d want all zero",
               up, down, done, cnt_a, cnt_b);
    end
    sb_q.push_back({1'b1, 1'b0, 16'd2, 16'd1});
    run_window(1'b0, 4, 2, 1, o, to, lat);
    e = sb_q.pop_front();
    checks++;
    if (to || o.m !== e) begin errors++; $display("FAIL midreset_result got %h want %h timeout=%b", o.m, e, to); end
    checks++;
    if (lat != LAT) begin errors++; $display("FAIL midreset_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_back_to_back();
    int ndone, overlap, last_c, bad_gap;
    res_t e;
    enable = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    repeat (2) @(negedge clk);
    enable = 1'b1;
    for (int w = 0; w < 3; w++) sb_q.push_back({1'b1, 1'b0, 16'd0, 16'd0});
    ndone = 0; overlap = 0; last_c = -1; bad_gap = 0;
    for (int c = 0; c < 210; c++) begin
      @(negedge clk);
      if (up && down) overlap++;
      if (done) begin
        ndone++;
        if (last_c >= 0 && (c - last_c) != WIN + 1) bad_gap++;
        last_c = c;
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          checks++;
          if ({up, down} !== {e.up, e.down}) begin
            errors++; $display("FAIL b2b_direction got %b want %b", {up, down}, {e.up, e.down});
          end
        end
      end
      ro_a = (c % 4) < 2;
      ro_b = (c % 8) < 4;
    end
    enable = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    checks++;
    if (ndone != 3) begin errors++; $display("FAIL b2b_count got %0d windows want 3", ndone); end
    checks++;
    if (bad_gap != 0) begin errors++; $display("FAIL b2b_period got %0d bad gaps want 0", bad_gap); end
    checks++;
    if (overlap != 0) begin errors++; $display("FAIL b2b_overlap got %0d cycles want 0", overlap); end
    checks++;
    if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_scoreboard got %0d left want 0", sb_q.size()); end
    repeat (4) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; ro_a = 1'b0; ro_b = 1'b0;
    test_reset();
    test_basic();
    test_swapped_equal();
    test_deadband();
    test_saturation();
    test_abort();
    test_reset_mid_window();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
